// File: rtl/sha1_pkg.sv
// SHA-1 shared definitions: IV, round constants, working-state type and the single-round function.
package sha1_pkg;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} sha1_fsm_t;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] c;
        logic [31:0] d;
        logic [31:0] e;
    } sha1_state_t;

    localparam logic [31:0] SHA1_IV [0:4] = '{
        32'h67452301, 32'hEFCDAB89, 32'h98BADCFE, 32'h10325476, 32'hC3D2E1F0
    };

    localparam logic [31:0] K_00_19 = 32'h5A827999;
    localparam logic [31:0] K_20_39 = 32'h6ED9EBA1;
    localparam logic [31:0] K_40_59 = 32'h8F1BBCDC;
    localparam logic [31:0] K_60_79 = 32'hCA62C1D6;

    function automatic logic [31:0] rotl(input logic [31:0] x, input int unsigned n);
        return (x << n) | (x >> (32 - n));
    endfunction

    function automatic logic [31:0] f_ch(input logic [31:0] b, input logic [31:0] c,
                                         input logic [31:0] d);
        return (b & c) | (~b & d);
    endfunction

    function automatic logic [31:0] f_par(input logic [31:0] b, input logic [31:0] c,
                                          input logic [31:0] d);
        return b ^ c ^ d;
    endfunction

    function automatic logic [31:0] f_maj(input logic [31:0] b, input logic [31:0] c,
                                          input logic [31:0] d);
        return (b & c) ^ (b & d) ^ (c & d);
    endfunction

    function automatic sha1_state_t iv_state();
        return {SHA1_IV[0], SHA1_IV[1], SHA1_IV[2], SHA1_IV[3], SHA1_IV[4]};
    endfunction

    function automatic sha1_state_t add_state(input sha1_state_t x, input sha1_state_t y);
        sha1_state_t r;
        r.a = x.a + y.a;
        r.b = x.b + y.b;
        r.c = x.c + y.c;
        r.d = x.d + y.d;
        r.e = x.e + y.e;
        return r;
    endfunction

    // f/K are selected per round so unrolled groups may cross a 20-round boundary.
    function automatic sha1_state_t sha1_round(input sha1_state_t s, input logic [31:0] w,
                                               input logic [6:0] t);
        sha1_state_t n;
        logic [31:0] f;
        logic [31:0] k;
        if (t < 7'd20) begin
            f = f_ch(s.b, s.c, s.d);
            k = K_00_19;
        end else if (t < 7'd40) begin
            f = f_par(s.b, s.c, s.d);
            k = K_20_39;
        end else if (t < 7'd60) begin
            f = f_maj(s.b, s.c, s.d);
            k = K_40_59;
        end else begin
            f = f_par(s.b, s.c, s.d);
            k = K_60_79;
        end
        n.a = rotl(s.a, 5) + f + s.e + k + w;
        n.b = s.a;
        n.c = rotl(s.b, 30);
        n.d = s.c;
        n.e = s.d;
        return n;
    endfunction

endpackage

// File: rtl/sha1_wsched.sv
// SHA-1 message schedule: 16-word sliding window emitting RPC consecutive W_t words per cycle.
module sha1_wsched
    import sha1_pkg::*;
#(
    parameter int unsigned RPC = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              advance,
    input  logic [511:0]      block_i,
    output logic [32*RPC-1:0] w_o
);

    // Window word i (W_{t+i}) lives at bits [32*i +: 32]; word 0 is the current W_t.
    logic [511:0]            win;
    logic [511:0]            blk_le;
    logic [32*(16+RPC)-1:0]  ext;

    function automatic logic [32*(16+RPC)-1:0] expand(input logic [511:0] cur);
        logic [32*(16+RPC)-1:0] e;
        e = {{(32*RPC){1'b0}}, cur};
        for (int unsigned i = 16; i < 16 + RPC; i++)
            e[32*i +: 32] = rotl(e[32*(i-3) +: 32] ^ e[32*(i-8) +: 32] ^
                                 e[32*(i-14) +: 32] ^ e[32*(i-16) +: 32], 1);
        return e;
    endfunction

    always_comb begin
        blk_le = '0;
        for (int unsigned i = 0; i < 16; i++)
            blk_le[32*i +: 32] = block_i[511-32*i -: 32];
    end

    assign ext = expand(win);
    assign w_o = ext[32*RPC-1:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            win <= '0;
        else if (load)
            win <= blk_le;
        else if (advance)
            win <= ext[32*RPC +: 512];
    end

endmodule

// File: rtl/sha1_compress.sv
// Iterative SHA-1 compression engine, ROUNDS_PER_CYCLE rounds per clock.
// Define SHA1_MIDSTATE_EN to add mid_i/mid_load_i for resuming from a saved chaining value.
module sha1_compress
    import sha1_pkg::*;
#(
    parameter int unsigned ROUNDS_PER_CYCLE = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [511:0] block_i,
    input  logic         first_i,
`ifdef SHA1_MIDSTATE_EN
    input  logic [159:0] mid_i,
    input  logic         mid_load_i,
`endif
    output logic         out_valid,
    input  logic         out_ready,
    output logic [159:0] digest_o
);

    localparam int unsigned LAT    = 80 / ROUNDS_PER_CYCLE;
    localparam logic [6:0]  LAST_T = 7'((LAT - 1) * ROUNDS_PER_CYCLE);

    if ((80 % ROUNDS_PER_CYCLE) != 0 || ROUNDS_PER_CYCLE > 20) begin : g_bad_rpc
        $error("ROUNDS_PER_CYCLE must divide 80 and be at most 20");
    end

    sha1_fsm_t                        state_q, state_d;
    sha1_state_t                      h_q, st_q, st_next, base, h_sum;
    logic [6:0]                       t_q;
    logic [32*ROUNDS_PER_CYCLE-1:0]   w_grp;
    logic                             accept, last_grp, busy;

    function automatic sha1_state_t rounds(input sha1_state_t s,
                                           input logic [32*ROUNDS_PER_CYCLE-1:0] w,
                                           input logic [6:0] t);
        sha1_state_t r;
        r = s;
        for (int unsigned j = 0; j < ROUNDS_PER_CYCLE; j++)
            r = sha1_round(r, w[32*j +: 32], t + 7'(j));
        return r;
    endfunction

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q == BUSY);
    assign accept    = in_ready && in_valid;
    assign last_grp  = busy && (t_q == LAST_T);
    assign st_next   = rounds(st_q, w_grp, t_q);
    assign h_sum     = add_state(h_q, st_next);

    always_comb begin
`ifdef SHA1_MIDSTATE_EN
        base = first_i ? (mid_load_i ? sha1_state_t'(mid_i) : iv_state()) : h_q;
`else
        base = first_i ? iv_state() : h_q;
`endif
    end

    sha1_wsched #(
        .RPC (ROUNDS_PER_CYCLE)
    ) u_wsched (
        .clk     (clk),
        .rst     (rst),
        .load    (accept),
        .advance (busy),
        .block_i (block_i),
        .w_o     (w_grp)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (in_valid)  state_d = BUSY;
            BUSY:    if (last_grp)  state_d = DONE;
            DONE:    if (out_ready) state_d = IDLE;
            default:                state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            h_q      <= iv_state();
            st_q     <= '0;
            t_q      <= '0;
            digest_o <= '0;
        end else if (accept) begin
            h_q  <= base;
            st_q <= base;
            t_q  <= '0;
        end else if (busy) begin
            st_q <= st_next;
            t_q  <= last_grp ? '0 : t_q + 7'(ROUNDS_PER_CYCLE);
            if (last_grp) begin
                h_q      <= h_sum;
                digest_o <= h_sum;
            end
        end
    end

endmodule

// File: tb/tb_sha1_compress.sv
// Bench: every legal ROUNDS_PER_CYCLE instance driven in lockstep, checked each cycle against a plain SHA-1 model.
module tb_sha1_compress;

    localparam int NI = 8;
    localparam logic [159:0] IV = 160'h67452301_EFCDAB89_98BADCFE_10325476_C3D2E1F0;
`ifdef SHA1_MIDSTATE_EN
    localparam bit MID_EN = 1'b1;
`else
    localparam bit MID_EN = 1'b0;
`endif

    localparam logic [511:0] ABC   = {32'h61626380, {14{32'h0}}, 32'h00000018};
    localparam logic [511:0] EMPTY = {32'h80000000, {15{32'h0}}};
    localparam logic [511:0] B1 = {
        32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
        32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
        32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
        32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
    localparam logic [511:0] B2 = {{15{32'h0}}, 32'h000001c0};

    function automatic int rpc_of(input int g);
        case (g)
            0: return 1;
            1: return 2;
            2: return 4;
            3: return 5;
            4: return 8;
            5: return 10;
            6: return 16;
            default: return 20;
        endcase
    endfunction

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic [511:0] block_i;
    logic         first_i;
    logic [159:0] mid_i;
    logic         mid_load_i;
    logic         out_ready;
    logic         in_ready  [NI];
    logic         out_valid [NI];
    logic [159:0] digest    [NI];

    int           vectors = 0;
    int           miscompares = 0;
    int           cyc = 0;
    int           acc_cyc = 0;
    logic [NI-1:0] pend = '0;
    logic [159:0] model_h = IV;
    logic [159:0] exp_dig = '0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        sha1_compress #(
            .ROUNDS_PER_CYCLE (rpc_of(g))
        ) u_dut (
            .clk        (clk),
            .rst        (rst),
            .in_valid   (in_valid),
            .in_ready   (in_ready[g]),
            .block_i    (block_i),
            .first_i    (first_i),
`ifdef SHA1_MIDSTATE_EN
            .mid_i      (mid_i),
            .mid_load_i (mid_load_i),
`endif
            .out_valid  (out_valid[g]),
            .out_ready  (out_ready),
            .digest_o   (digest[g])
        );
    end

    // Straight FIPS 180 compression: full 80-entry schedule, then 80 rounds.
    function automatic logic [159:0] ref_compress(input logic [159:0] hin, input logic [511:0] blk);
        logic [31:0] w [80];
        logic [31:0] a, b, c, d, e, f, k, tmp;
        for (int i = 0; i < 16; i++) w[i] = blk[511-32*i -: 32];
        for (int i = 16; i < 80; i++) begin
            tmp  = w[i-3] ^ w[i-8] ^ w[i-14] ^ w[i-16];
            w[i] = {tmp[30:0], tmp[31]};
        end
        {a, b, c, d, e} = hin;
        for (int i = 0; i < 80; i++) begin
            case (i / 20)
                0:       begin f = (b & c) | (~b & d);          k = 32'h5A827999; end
                1:       begin f = b ^ c ^ d;                   k = 32'h6ED9EBA1; end
                2:       begin f = (b & c) | (b & d) | (c & d); k = 32'h8F1BBCDC; end
                default: begin f = b ^ c ^ d;                   k = 32'hCA62C1D6; end
            endcase
            tmp = {a[26:0], a[31:27]} + f + e + k + w[i];
            e = d; d = c; c = {b[1:0], b[31:2]}; b = a; a = tmp;
        end
        return {hin[159:128] + a, hin[127:96] + b, hin[95:64] + c, hin[63:32] + d, hin[31:0] + e};
    endfunction

    task automatic chk(input string what, input int ctx, input logic [159:0] got,
                       input logic [159:0] want);
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("FAIL %s ctx=%0d cyc=%0d got %h want %h", what, ctx, cyc, got, want);
        end
    endtask

    function automatic bit all_valid();
        for (int g = 0; g < NI; g++)
            if (out_valid[g] !== 1'b1) return 1'b0;
        return 1'b1;
    endfunction

    // Per-cycle compare against the transaction-level model.
    always @(negedge clk) begin
        logic          acc;
        logic          exp_ov;
        logic [159:0]  base;
        logic [NI-1:0] drop;
        cyc++;
        if (rst) begin
            for (int g = 0; g < NI; g++) begin
                chk("rst_in_ready",  rpc_of(g), 160'(in_ready[g]),  160'd1);
                chk("rst_out_valid", rpc_of(g), 160'(out_valid[g]), 160'd0);
                chk("rst_digest",    rpc_of(g), digest[g],          160'd0);
            end
            pend    = '0;
            model_h = IV;
        end else begin
            acc  = in_valid && (pend == '0);
            drop = '0;
            for (int g = 0; g < NI; g++) begin
                exp_ov = pend[g] && (cyc - acc_cyc >= 80 / rpc_of(g) + 1);
                chk("in_ready",  rpc_of(g), 160'(in_ready[g]),  160'(!pend[g]));
                chk("out_valid", rpc_of(g), 160'(out_valid[g]), 160'(exp_ov));
                if (exp_ov) begin
                    chk("digest", rpc_of(g), digest[g], exp_dig);
                    if (out_ready) drop[g] = 1'b1;
                end
            end
            pend = pend & ~drop;
            if (acc) begin
                base    = first_i ? ((MID_EN && mid_load_i) ? mid_i : IV) : model_h;
                exp_dig = ref_compress(base, block_i);
                model_h = exp_dig;
                pend    = '1;
                acc_cyc = cyc;
            end
        end
    end

    task automatic xact(input logic [511:0] blk, input logic fst, input logic ml,
                        input logic [159:0] mv, input int hold);
        int n;
        in_valid = 1'b1; block_i = blk; first_i = fst; mid_load_i = ml; mid_i = mv;
        @(posedge clk); #1;
        n = 0;
        while (!all_valid() && n < 200) begin
            in_valid = 1'($urandom); first_i = 1'($urandom); block_i = {16{$urandom}};
            @(posedge clk); #1;
            n++;
        end
        if (n >= 200) begin
            vectors++; miscompares++;
            $display("FAIL out_valid_timeout cyc=%0d got 0 want 1", cyc);
        end
        repeat (hold) begin
            in_valid = 1'($urandom);
            @(posedge clk); #1;
        end
        out_ready = 1'b1; in_valid = 1'($urandom);
        @(posedge clk); #1;
        out_ready = 1'b0; in_valid = 1'b0;
        @(posedge clk); #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog cyc=%0d got timeout want finish", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [511:0] rblk;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; block_i = '0; first_i = 1'b0;
        mid_i = '0; mid_load_i = 1'b0;

        chk("pin_abc",   0, ref_compress(IV, ABC),
            160'ha9993e36_4706816a_ba3e2571_7850c26c_9cd0d89d);
        chk("pin_empty", 0, ref_compress(IV, EMPTY),
            160'hda39a3ee_5e6b4b0d_3255bfef_95601890_afd80709);
        chk("pin_two",   0, ref_compress(ref_compress(IV, B1), B2),
            160'h84983e44_1c3bd26e_baae4aa1_f95129e5_e54670f1);

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk); #1;

        xact(ABC,   1'b1, 1'b0, '0, 0);
        xact(EMPTY, 1'b1, 1'b0, '0, 2);
        xact(B1,    1'b1, 1'b0, '0, 0);
        xact(B2,    1'b0, 1'b0, '0, 10);

        // Abort mid-block (round 40 of the RPC=1 instance), then chain from IV with first_i=0.
        in_valid = 1'b1; block_i = ABC; first_i = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (40) @(posedge clk);
        #2 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(posedge clk); #1;
        xact(ABC, 1'b0, 1'b0, '0, 1);

        xact(B2, 1'b1, 1'b1, ref_compress(IV, B1), 0);

        for (int i = 0; i < 6; i++) begin
            for (int j = 0; j < 16; j++) rblk[32*j +: 32] = $urandom;
            xact(rblk, 1'($urandom), 1'($urandom),
                 {$urandom, $urandom, $urandom, $urandom, $urandom}, $urandom_range(0, 3));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
